// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_defs: shared definitions for the CPU memory-bus arbiter.
//   arb_state_t - arbiter FSM states
//   SIZE_*      - bus transfer size encodings (byte / half / word)
package cpu_bus_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_ADDR,
        ST_D_WAIT,
        ST_I_ADDR,
        ST_I_WAIT
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cpu_bus_arbiter_bus_req_hold.sv
// bus_req_hold: holds the request fields of the transaction currently on the
// bus so they stay stable while the requester's own inputs may change.
//   clk, rst                          - clock, synchronous active-high reset
//   load                              - capture the new_* fields this cycle
//   new_addr/new_wr/new_size/new_wdata - fields of the selected requester
//   addr/wr/size/wdata                - held fields driving the bus
module bus_req_hold #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic              new_wr,
    input  logic [1:0]        new_size,
    input  logic [DATA_W-1:0] new_wdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [1:0]        size,
    output logic [DATA_W-1:0] wdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            wr    <= 1'b0;
            size  <= '0;
            wdata <= '0;
        end else if (load) begin
            addr  <= new_addr;
            wr    <= new_wr;
            size  <= new_size;
            wdata <= new_wdata;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one SRAM-like bus between instruction fetch and
// data access, one outstanding transaction, data first. Completed results
// are buffered and flagged done until the whole pipeline advances.
//   clk, rst                        - clock, synchronous active-high reset
//   inst_req/inst_addr              - fetch request (held until advance)
//   inst_rdata, i_stall             - buffered instruction, fetch pending
//   data_req/wr/size/addr/wdata     - load/store request (held until advance)
//   data_rdata, d_stall             - buffered load data, access pending
//   longest_stall                   - pipeline frozen by another source
//   bus_req/wr/size/addr/wdata      - bus request channel
//   bus_addr_ok, bus_data_ok        - bus handshakes
//   bus_rdata                       - bus read data
module cpu_bus_arbiter
    import cpu_bus_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              i_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              inst_done;
    logic              data_done;
    logic [DATA_W-1:0] inst_buf;
    logic [DATA_W-1:0] data_buf;
    logic              advance;
    logic              load_hold;
    logic              sel_data;
    logic              set_inst;
    logic              set_data;

    logic [ADDR_W-1:0] hold_addr;
    logic              hold_wr;
    logic [1:0]        hold_size;
    logic [DATA_W-1:0] hold_wdata;

    assign i_stall    = inst_req & ~inst_done;
    assign d_stall    = data_req & ~data_done;
    assign advance    = ~i_stall & ~d_stall & ~longest_stall;
    assign inst_rdata = inst_buf;
    assign data_rdata = data_buf;

    // Fetches are always word reads; wdata is zeroed so the bus sees a clean value.
    assign hold_addr  = sel_data ? data_addr  : inst_addr;
    assign hold_wr    = sel_data ? data_wr    : 1'b0;
    assign hold_size  = sel_data ? data_size  : SIZE_WORD;
    assign hold_wdata = sel_data ? data_wdata : '0;

    bus_req_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load_hold),
        .new_addr  (hold_addr),
        .new_wr    (hold_wr),
        .new_size  (hold_size),
        .new_wdata (hold_wdata),
        .addr      (bus_addr),
        .wr        (bus_wr),
        .size      (bus_size),
        .wdata     (bus_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_hold  = 1'b0;
        sel_data   = 1'b0;
        bus_req    = 1'b0;
        set_inst   = 1'b0;
        set_data   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_stall) begin
                    next_state = ST_D_ADDR;
                    load_hold  = 1'b1;
                    sel_data   = 1'b1;
                end else if (i_stall) begin
                    next_state = ST_I_ADDR;
                    load_hold  = 1'b1;
                end
            end
            ST_D_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) next_state = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                if (bus_data_ok) begin
                    set_data = 1'b1;
                    // Chain straight into a pending fetch without an IDLE bubble.
                    if (i_stall) begin
                        next_state = ST_I_ADDR;
                        load_hold  = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_I_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) next_state = ST_I_WAIT;
            end
            ST_I_WAIT: begin
                if (bus_data_ok) begin
                    set_inst   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Done flags and buffers persist until advance, so a result that arrives
    // while the pipe is frozen is neither lost nor fetched again.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
            inst_buf  <= '0;
            data_buf  <= '0;
        end else begin
            if (advance) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
            if (set_inst) begin
                inst_done <= 1'b1;
                inst_buf  <= bus_rdata;
            end
            if (set_data) begin
                data_done <= 1'b1;
                if (!bus_wr) data_buf <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed scenarios plus a randomized transaction-level
// check of cpu_bus_arbiter against a bus-slave model and expected results.
module tb_cpu_bus_arbiter;
    import cpu_bus_defs::*;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_ibuf;
    logic [31:0] exp_dbuf;

    cpu_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_size      (bus_size),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- bus slave model ----------------
    int unsigned addr_lat = 0;
    int unsigned data_lat = 1;
    int unsigned sl_cnt   = 0;
    logic        sl_busy  = 1'b0;
    logic        sl_wr    = 1'b0;
    logic [31:0] sl_addr  = '0;
    txn_t        bus_log[$];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
        if (rst) begin
            sl_busy = 1'b0;
            sl_cnt  = 0;
        end else if (!sl_busy) begin
            if (bus_req) begin
                if (sl_cnt >= addr_lat) begin
                    bus_addr_ok = 1'b1;
                    bus_log.push_back('{bus_wr, bus_size, bus_addr, bus_wdata});
                    sl_wr   = bus_wr;
                    sl_addr = bus_addr;
                    sl_busy = 1'b1;
                    sl_cnt  = 0;
                end else begin
                    sl_cnt++;
                end
            end
        end else begin
            sl_cnt++;
            if (sl_cnt >= data_lat) begin
                bus_data_ok = 1'b1;
                bus_rdata   = sl_wr ? $urandom : mem_rd(sl_addr);
                sl_busy     = 1'b0;
                sl_cnt      = 0;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL reset_i_stall: got %b want 0", i_stall); end
        n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL reset_d_stall: got %b want 0", d_stall); end
        n_tests++; if (inst_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_inst_rdata: got %h want 0", inst_rdata); end
        n_tests++; if (data_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data_rdata: got %h want 0", data_rdata); end
        inst_req = 1'b1; data_req = 1'b1;
        #1;
        n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL reset_i_stall_req: got %b want 1", i_stall); end
        n_tests++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL reset_d_stall_req: got %b want 1", d_stall); end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lone_load();
        logic [3:0] trace;
        addr_lat = 0; data_lat = 1;
        mem[32'h0000_1000] = 32'hDEAD_BEEF;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD;
        data_addr = 32'h0000_1000; data_wdata = $urandom;
        #1;
        for (int c = 0; c < 4; c++) begin
            trace[c] = bus_req;
            if (c == 1) begin
                n_tests++; if (bus_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL load_bus_addr: got %h want 00001000", bus_addr); end
                n_tests++; if (bus_wr !== 1'b0) begin n_fail++; $display("FAIL load_bus_wr: got %b want 0", bus_wr); end
            end
            if (c == 2) begin
                n_tests++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL load_d_stall_c2: got %b want 1", d_stall); end
            end
            if (c < 3) @(negedge clk);
        end
        n_tests++; if (trace !== 4'b0010) begin n_fail++; $display("FAIL load_bus_req_trace: got %b want 0010", trace); end
        n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL load_d_stall_c3: got %b want 0", d_stall); end
        n_tests++; if (data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", data_rdata); end
        exp_dbuf = 32'hDEAD_BEEF;
        data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        logic [5:0] trace;
        addr_lat = 0; data_lat = 1;
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_HALF; data_addr = 32'h0000_2002;
        #1;
        for (int c = 0; c < 6; c++) begin
            trace[c] = bus_req;
            if (c == 1) begin
                n_tests++; if (bus_addr !== 32'h0000_2002) begin n_fail++; $display("FAIL simul_data_first: got addr %h want 00002002", bus_addr); end
                n_tests++; if (bus_size !== SIZE_HALF) begin n_fail++; $display("FAIL simul_data_size: got %0d want 1", bus_size); end
            end
            if (c == 3) begin
                n_tests++; if (bus_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL simul_fetch_addr: got %h want 00000400", bus_addr); end
                n_tests++; if ({bus_wr, bus_size} !== 3'b010) begin n_fail++; $display("FAIL simul_fetch_wr_size: got %b want 010", {bus_wr, bus_size}); end
                n_tests++; if ({i_stall, d_stall} !== 2'b10) begin n_fail++; $display("FAIL simul_stalls_c3: got %b want 10", {i_stall, d_stall}); end
            end
            if (c < 5) @(negedge clk);
        end
        n_tests++; if (trace !== 6'b001010) begin n_fail++; $display("FAIL simul_bus_req_trace: got %b want 001010", trace); end
        n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL simul_i_stall_c5: got %b want 0", i_stall); end
        exp_ibuf = mem_rd(32'h0000_0400);
        exp_dbuf = mem_rd(32'h0000_2002);
        n_tests++; if (inst_rdata !== exp_ibuf) begin n_fail++; $display("FAIL simul_inst_rdata: got %h want %h", inst_rdata, exp_ibuf); end
        n_tests++; if (data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL simul_data_rdata: got %h want %h", data_rdata, exp_dbuf); end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_in_flight();
        logic [8:0]  trace;
        int unsigned k;
        addr_lat = 0; data_lat = 5;
        inst_req = 1'b1; inst_addr = 32'h0000_0800; data_req = 1'b0;
        #1;
        for (int c = 0; c < 9; c++) begin
            trace[c] = bus_req;
            if (c == 2) begin
                data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h0000_3000;
            end
            if (c == 7) begin
                n_tests++; if ({i_stall, d_stall} !== 2'b01) begin n_fail++; $display("FAIL flight_stalls_c7: got %b want 01", {i_stall, d_stall}); end
                n_tests++; if (inst_rdata !== mem_rd(32'h0000_0800)) begin n_fail++; $display("FAIL flight_inst_rdata: got %h want %h", inst_rdata, mem_rd(32'h0000_0800)); end
            end
            if (c == 8) begin
                n_tests++; if (bus_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL flight_data_addr: got %h want 00003000", bus_addr); end
            end
            if (c < 8) @(negedge clk);
        end
        n_tests++; if (trace !== 9'b1_0000_0010) begin n_fail++; $display("FAIL flight_bus_req_trace: got %b want 100000010", trace); end
        k = 0;
        while (d_stall && k < 20) begin @(negedge clk); k++; end
        n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL flight_data_timeout: d_stall got %b want 0", d_stall); end
        exp_ibuf = mem_rd(32'h0000_0800);
        exp_dbuf = mem_rd(32'h0000_3000);
        n_tests++; if (data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL flight_data_rdata: got %h want %h", data_rdata, exp_dbuf); end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divider_freeze();
        int unsigned k;
        addr_lat = 1; data_lat = 2;
        bus_log.delete();
        longest_stall = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0C00;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h0000_4444;
        #1;
        k = 0;
        while ((i_stall || d_stall) && k < 40) begin @(negedge clk); k++; end
        n_tests++; if ({i_stall, d_stall} !== 2'b00) begin n_fail++; $display("FAIL freeze_timeout: stalls got %b want 00", {i_stall, d_stall}); end
        exp_ibuf = mem_rd(32'h0000_0C00);
        exp_dbuf = mem_rd(32'h0000_4444);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++; if ({i_stall, d_stall, bus_req} !== 3'b000) begin n_fail++; $display("FAIL freeze_quiet: stalls/bus_req got %b want 000", {i_stall, d_stall, bus_req}); end
            n_tests++; if (inst_rdata !== exp_ibuf) begin n_fail++; $display("FAIL freeze_inst_buf: got %h want %h", inst_rdata, exp_ibuf); end
            n_tests++; if (data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL freeze_data_buf: got %h want %h", data_rdata, exp_dbuf); end
        end
        n_tests++; if (bus_log.size() !== 2) begin n_fail++; $display("FAIL freeze_handshakes: got %0d want 2", bus_log.size()); end
        longest_stall = 1'b0;
        @(negedge clk);
        // requests still held: cleared flags make both stalls reappear
        n_tests++; if ({i_stall, d_stall} !== 2'b11) begin n_fail++; $display("FAIL freeze_flags_cleared: stalls got %b want 11", {i_stall, d_stall}); end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        int unsigned hi;
        int unsigned k;
        addr_lat = 3; data_lat = 1;
        data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_BYTE;
        data_wdata = 32'h0000_00AB; data_addr = 32'h0000_5001; inst_req = 1'b0;
        #1;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_req) begin
                hi++;
                n_tests++; if ({bus_wr, bus_size} !== 3'b100) begin n_fail++; $display("FAIL store_wr_size: got %b want 100", {bus_wr, bus_size}); end
                n_tests++; if (bus_wdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL store_wdata: got %h want 000000ab", bus_wdata); end
                n_tests++; if (bus_addr !== 32'h0000_5001) begin n_fail++; $display("FAIL store_addr: got %h want 00005001", bus_addr); end
                if (bus_addr_ok) break;
            end
        end
        n_tests++; if (hi !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", hi); end
        k = 0;
        while (d_stall && k < 20) begin @(negedge clk); k++; end
        n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL store_timeout: d_stall got %b want 0", d_stall); end
        n_tests++; if (data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL store_buf_unchanged: got %h want %h", data_rdata, exp_dbuf); end
        data_req = 1'b0; data_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_dwait();
        int unsigned k;
        addr_lat = 0; data_lat = 6;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h0000_6000;
        #1;
        @(negedge clk);
        n_tests++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstw_issue: bus_req got %b want 1", bus_req); end
        @(negedge clk);
        n_tests++; if ({bus_req, d_stall} !== 2'b01) begin n_fail++; $display("FAIL rstw_wait: bus_req/d_stall got %b want 01", {bus_req, d_stall}); end
        rst = 1'b1;
        @(negedge clk);
        exp_ibuf = '0; exp_dbuf = '0;
        n_tests++; if ({bus_req, d_stall} !== 2'b01) begin n_fail++; $display("FAIL rstw_after: bus_req/d_stall got %b want 01", {bus_req, d_stall}); end
        n_tests++; if ({inst_rdata, data_rdata} !== 64'h0) begin n_fail++; $display("FAIL rstw_bufs: got %h want 0", {inst_rdata, data_rdata}); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_6000) begin n_fail++; $display("FAIL rstw_reissue: bus_req %b addr %h want 1 00006000", bus_req, bus_addr); end
        k = 0;
        while (d_stall && k < 20) begin @(negedge clk); k++; end
        exp_dbuf = mem_rd(32'h0000_6000);
        n_tests++; if (d_stall !== 1'b0 || data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL rstw_complete: d_stall %b rdata %h want 0 %h", d_stall, data_rdata, exp_dbuf); end
        data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            logic        has_i;
            logic        has_d;
            int unsigned ls_n;
            int unsigned k;
            int unsigned n;
            txn_t        exp_q[$];
            has_i = ($urandom_range(0, 3) != 0);
            has_d = $urandom_range(0, 1);
            if (!has_i && !has_d) has_d = 1'b1;
            addr_lat = $urandom_range(0, 3);
            data_lat = $urandom_range(1, 4);
            ls_n     = $urandom_range(0, 3);
            inst_addr  = $urandom & 32'hFFFF_FFFC;
            data_wr    = $urandom_range(0, 1);
            data_size  = $urandom_range(0, 2);
            data_addr  = $urandom;
            data_wdata = $urandom;
            bus_log.delete();
            if (has_d) exp_q.push_back('{data_wr, data_size, data_addr, data_wdata});
            if (has_i) exp_q.push_back('{1'b0, SIZE_WORD, inst_addr, 32'h0});
            inst_req = has_i; data_req = has_d; longest_stall = (ls_n != 0);
            #1;
            k = 0;
            while ((i_stall || d_stall) && k < 80) begin @(negedge clk); k++; end
            n_tests++; if ({i_stall, d_stall} !== 2'b00) begin n_fail++; $display("FAIL rand_timeout step %0d: stalls got %b want 00", s, {i_stall, d_stall}); end
            if (has_d && !data_wr) exp_dbuf = mem_rd(data_addr);
            if (has_i) exp_ibuf = mem_rd(inst_addr);
            n_tests++; if (data_rdata !== exp_dbuf) begin n_fail++; $display("FAIL rand_data_rdata step %0d: got %h want %h", s, data_rdata, exp_dbuf); end
            n_tests++; if (inst_rdata !== exp_ibuf) begin n_fail++; $display("FAIL rand_inst_rdata step %0d: got %h want %h", s, inst_rdata, exp_ibuf); end
            for (int j = 0; j < int'(ls_n); j++) begin
                @(negedge clk);
                n_tests++; if ({i_stall, d_stall, bus_req} !== 3'b000) begin n_fail++; $display("FAIL rand_frozen step %0d: got %b want 000", s, {i_stall, d_stall, bus_req}); end
            end
            n_tests++; if (bus_log.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_txn_count step %0d: got %0d want %0d", s, bus_log.size(), exp_q.size()); end
            n = (bus_log.size() < exp_q.size()) ? bus_log.size() : exp_q.size();
            for (int j = 0; j < int'(n); j++) begin
                n_tests++;
                if (bus_log[j].wr !== exp_q[j].wr || bus_log[j].size !== exp_q[j].size || bus_log[j].addr !== exp_q[j].addr
                    || (exp_q[j].wr && bus_log[j].wdata !== exp_q[j].wdata)) begin
                    n_fail++;
                    $display("FAIL rand_txn step %0d #%0d: got wr%b sz%0d a%h d%h want wr%b sz%0d a%h d%h", s, j,
                             bus_log[j].wr, bus_log[j].size, bus_log[j].addr, bus_log[j].wdata,
                             exp_q[j].wr, exp_q[j].size, exp_q[j].addr, exp_q[j].wdata);
                end
            end
            longest_stall = 1'b0; inst_req = 1'b0; data_req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_size = SIZE_WORD; data_addr = '0; data_wdata = '0; longest_stall = 1'b0;
        exp_ibuf = '0; exp_dbuf = '0;
        @(negedge clk);
        test_reset();
        test_lone_load();
        test_simultaneous();
        test_fetch_in_flight();
        test_divider_freeze();
        test_store();
        test_reset_dwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
